// File: rtl/fir_tap_multiplier.sv
// Front end of the FIR datapath: sample delay line, double-buffered coefficient bank and one
// registered full-width signed product per tap, feeding the downstream pipelined adder tree.
module fir_tap_multiplier #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 53,
  localparam int TREE_STAGES = $clog2(NUM_TAPS),
  localparam int PROD_WIDTH  = DATA_WIDTH + COEF_WIDTH,
  localparam int ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         flush,
  input  logic                         coef_we,
  input  logic [ADDR_WIDTH-1:0]        coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wdata,
  input  logic                         coef_swap,
  output logic                         swap_pending,
  output logic                         swap_done,
  output logic signed [PROD_WIDTH-1:0] prod [NUM_TAPS],
  output logic                         prod_valid,
  output logic                         sum_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

  swap_state_t state_reg, state_next;
  logic        apply_next;

  logic signed [DATA_WIDTH-1:0] x_reg     [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] c_shd_reg [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] c_act_reg [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0] mult      [NUM_TAPS];
  logic                         v1_reg;
  logic [TREE_STAGES-1:0]       sv_chain_reg;
  logic                         shd_wr;
  logic                         prod_load;

  assign shd_wr    = coef_we && (coef_addr <= LAST_TAP);
  assign prod_load = v1_reg && !flush;

  // Operands are sign-extended to the product width so the multiply is exact.
  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic signed [PROD_WIDTH-1:0] x_ext;
      logic signed [PROD_WIDTH-1:0] c_ext;
      assign x_ext    = {{COEF_WIDTH{x_reg[gi][DATA_WIDTH-1]}}, x_reg[gi]};
      assign c_ext    = {{DATA_WIDTH{c_act_reg[gi][COEF_WIDTH-1]}}, c_act_reg[gi]};
      assign mult[gi] = x_ext * c_ext;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_TAPS; k++) x_reg[k] <= '0;
      v1_reg <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < NUM_TAPS; k++) x_reg[k] <= '0;
      v1_reg <= 1'b0;
    end else if (in_valid) begin
      x_reg[0] <= in_data;
      for (int k = 1; k < NUM_TAPS; k++) x_reg[k] <= x_reg[k-1];
      v1_reg <= 1'b1;
    end else begin
      v1_reg <= 1'b0;
    end
  end

  // Products hold across flush so the tree input stays stable; only the valid is killed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_TAPS; k++) prod[k] <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= prod_load;
      if (prod_load) begin
        for (int k = 0; k < NUM_TAPS; k++) prod[k] <= mult[k];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sv_chain_reg <= '0;
    end else if (flush) begin
      sv_chain_reg <= '0;
    end else begin
      sv_chain_reg[0] <= prod_valid;
      for (int k = 1; k < TREE_STAGES; k++) sv_chain_reg[k] <= sv_chain_reg[k-1];
    end
  end

  assign sum_valid = sv_chain_reg[TREE_STAGES-1];

  // The copy reads the pre-edge shadow, so a same-edge shadow write is not included.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        c_shd_reg[k] <= '0;
        c_act_reg[k] <= '0;
      end
    end else begin
      if (shd_wr) c_shd_reg[coef_addr] <= coef_wdata;
      if (apply_next) begin
        for (int k = 0; k < NUM_TAPS; k++) c_act_reg[k] <= c_shd_reg[k];
      end
    end
  end

  // The bank only changes on an edge with no product update, so no update mixes banks.
  always_comb begin
    state_next = state_reg;
    apply_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (coef_swap) begin
          if (v1_reg) state_next = PEND;
          else        apply_next = 1'b1;
        end
      end
      PEND: begin
        if (!v1_reg) begin
          state_next = IDLE;
          apply_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      swap_done <= 1'b0;
    end else begin
      state_reg <= state_next;
      swap_done <= apply_next;
    end
  end

  assign swap_pending = (state_reg == PEND);

endmodule

// File: tb/tb_fir_tap_multiplier.sv
// Directed self-checking bench for fir_tap_multiplier: one task per scenario, inline comparisons
// against hand-computed values, one summary line at the end.
module tb_fir_tap_multiplier;

  localparam int DATA_WIDTH  = 16;
  localparam int COEF_WIDTH  = 16;
  localparam int NUM_TAPS    = 53;
  localparam int TREE_STAGES = $clog2(NUM_TAPS);
  localparam int PROD_WIDTH  = DATA_WIDTH + COEF_WIDTH;
  localparam int ADDR_WIDTH  = $clog2(NUM_TAPS);

  logic                         clk = 1'b0;
  logic                         resetn = 1'b0;
  logic                         in_valid = 1'b0;
  logic signed [DATA_WIDTH-1:0] in_data = '0;
  logic                         flush = 1'b0;
  logic                         coef_we = 1'b0;
  logic [ADDR_WIDTH-1:0]        coef_addr = '0;
  logic signed [COEF_WIDTH-1:0] coef_wdata = '0;
  logic                         coef_swap = 1'b0;
  logic                         swap_pending;
  logic                         swap_done;
  logic signed [PROD_WIDTH-1:0] prod [NUM_TAPS];
  logic                         prod_valid;
  logic                         sum_valid;

  int errors = 0;
  int checks = 0;

  fir_tap_multiplier #(
    .DATA_WIDTH(DATA_WIDTH),
    .COEF_WIDTH(COEF_WIDTH),
    .NUM_TAPS  (NUM_TAPS)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .flush       (flush),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_swap   (coef_swap),
    .swap_pending(swap_pending),
    .swap_done   (swap_done),
    .prod        (prod),
    .prod_valid  (prod_valid),
    .sum_valid   (sum_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sum_prod();
    longint s = 0;
    for (int k = 0; k < NUM_TAPS; k++) s += longint'(prod[k]);
    return s;
  endfunction

  function automatic int nonzero_prods();
    int n = 0;
    for (int k = 0; k < NUM_TAPS; k++) if (prod[k] !== '0) n++;
    return n;
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = ADDR_WIDTH'(addr);
    coef_wdata = COEF_WIDTH'(val);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Impulse into a flushed line: after k further samples, prod[k] = c_act[k].
  task automatic readback(input int k, output logic signed [PROD_WIDTH-1:0] v);
    do_flush();
    in_valid = 1'b1;
    in_data  = 16'sd1;
    tick();
    in_data = 16'sd0;
    repeat (k) tick();
    in_valid = 1'b0;
    tick();
    v = prod[k];
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 16'sd7;
    repeat (3) tick();
    checks++;
    if (prod_valid !== 1'b0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: prod_valid=%b sum_valid=%b required 0 0", prod_valid, sum_valid);
    end
    checks++;
    if (swap_pending !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_swap: pending=%b done=%b required 0 0", swap_pending, swap_done);
    end
    checks++;
    if (nonzero_prods() != 0) begin
      errors++;
      $display("FAIL reset_prod: %0d nonzero products, required 0", nonzero_prods());
    end
    in_valid = 1'b0;
    in_data  = 16'sd0;
    resetn   = 1'b1;
    tick();
    checks++;
    if (prod_valid !== 1'b0 || nonzero_prods() != 0) begin
      errors++;
      $display("FAIL reset_release: prod_valid=%b nonzero=%0d required 0 0", prod_valid, nonzero_prods());
    end
    $display("test_reset: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_impulse();
    logic signed [PROD_WIDTH-1:0] e;
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, k + 1);
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    checks++;
    if (swap_done !== 1'b1 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL impulse_swap: done=%b pending=%b required 1 0", swap_done, swap_pending);
    end
    in_valid = 1'b1;
    in_data  = 16'sd1;
    tick();
    in_data = 16'sd0;
    for (int j = 0; j < NUM_TAPS; j++) begin
      tick();
      e = PROD_WIDTH'(j + 1);
      checks++;
      if (prod_valid !== 1'b1 || prod[j] !== e) begin
        errors++;
        $display("FAIL impulse_tap%0d: prod_valid=%b prod=%0d required 1 %0d", j, prod_valid, prod[j], e);
      end
      checks++;
      if (sum_prod() != longint'(j + 1)) begin
        errors++;
        $display("FAIL impulse_sum%0d: sum=%0d required %0d", j, sum_prod(), j + 1);
      end
    end
    in_valid = 1'b0;
    repeat (TREE_STAGES + 4) tick();
    $display("test_impulse: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_latency();
    in_valid = 1'b1;
    in_data  = 16'sd1;
    for (int cnt = 1; cnt <= TREE_STAGES + 5; cnt++) begin
      tick();
      in_valid = 1'b0;
      checks++;
      if (prod_valid !== (cnt == 2) || sum_valid !== (cnt == 2 + TREE_STAGES)) begin
        errors++;
        $display("FAIL latency_edge%0d: prod_valid=%b sum_valid=%b required %b %b",
                 cnt, prod_valid, sum_valid, cnt == 2, cnt == 2 + TREE_STAGES);
      end
    end
    $display("test_latency: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_signed();
    logic signed [PROD_WIDTH-1:0] e_pos;
    logic signed [PROD_WIDTH-1:0] e_neg;
    e_pos = 32'sh40000000;
    e_neg = -32'sd1073709056;
    do_flush();
    write_coef(0, -32768);
    write_coef(1, -32768);
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL signed_swap: done=%b required 1", swap_done);
    end
    in_valid = 1'b1;
    in_data  = 16'sh7FFF;
    tick();
    in_data = 16'sh8000;
    tick();
    checks++;
    if (prod[0] !== e_neg) begin
      errors++;
      $display("FAIL signed_maxneg: prod0=%0d required %0d", prod[0], e_neg);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (prod[0] !== e_pos || prod_valid !== 1'b1) begin
      errors++;
      $display("FAIL signed_negneg: prod0=%0d valid=%b required %0d 1", prod[0], prod_valid, e_pos);
    end
    checks++;
    if (prod[1] !== e_neg || prod[2] !== '0) begin
      errors++;
      $display("FAIL signed_tap1: prod1=%0d prod2=%0d required %0d 0", prod[1], prod[2], e_neg);
    end
    $display("test_signed: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_swap_traffic();
    logic signed [PROD_WIDTH-1:0] e_old;
    logic signed [PROD_WIDTH-1:0] e_new;
    e_old = -32'sd65536;
    e_new = 32'sd6;
    do_flush();
    write_coef(0, 3);
    in_valid = 1'b1;
    in_data  = 16'sd2;
    tick();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    checks++;
    if (swap_pending !== 1'b1 || swap_done !== 1'b0 || prod[0] !== e_old) begin
      errors++;
      $display("FAIL swap_enter_pend: pending=%b done=%b prod0=%0d required 1 0 %0d",
               swap_pending, swap_done, prod[0], e_old);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) coef_swap = 1'b1;
      tick();
      coef_swap = 1'b0;
      checks++;
      if (swap_pending !== 1'b1 || swap_done !== 1'b0 || prod[0] !== e_old) begin
        errors++;
        $display("FAIL swap_hold%0d: pending=%b done=%b prod0=%0d required 1 0 %0d",
                 i, swap_pending, swap_done, prod[0], e_old);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (swap_pending !== 1'b1 || swap_done !== 1'b0 || prod_valid !== 1'b1 || prod[0] !== e_old) begin
      errors++;
      $display("FAIL swap_last_old: pending=%b done=%b valid=%b prod0=%0d required 1 0 1 %0d",
               swap_pending, swap_done, prod_valid, prod[0], e_old);
    end
    tick();
    checks++;
    if (swap_done !== 1'b1 || swap_pending !== 1'b0 || prod_valid !== 1'b0) begin
      errors++;
      $display("FAIL swap_apply: done=%b pending=%b valid=%b required 1 0 0",
               swap_done, swap_pending, prod_valid);
    end
    tick();
    checks++;
    if (swap_done !== 1'b0) begin
      errors++;
      $display("FAIL swap_single_pulse: done=%b required 0", swap_done);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (prod_valid !== 1'b1 || prod[0] !== e_new) begin
      errors++;
      $display("FAIL swap_new_bank: valid=%b prod0=%0d required 1 %0d", prod_valid, prod[0], e_new);
    end
    $display("test_swap_traffic: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_same_edge();
    logic signed [PROD_WIDTH-1:0] v;
    do_flush();
    write_coef(3, 5);
    coef_we    = 1'b1;
    coef_addr  = ADDR_WIDTH'(3);
    coef_wdata = 16'sd9;
    coef_swap  = 1'b1;
    tick();
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_swap: done=%b required 1", swap_done);
    end
    readback(3, v);
    checks++;
    if (v !== 32'sd5) begin
      errors++;
      $display("FAIL same_edge_old: c_act3=%0d required 5", v);
    end
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_swap2: done=%b required 1", swap_done);
    end
    readback(3, v);
    checks++;
    if (v !== 32'sd9) begin
      errors++;
      $display("FAIL same_edge_new: c_act3=%0d required 9", v);
    end
    $display("test_same_edge: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flush();
    logic signed [PROD_WIDTH-1:0] v;
    int bad;
    do_flush();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DATA_WIDTH'(i + 1);
      tick();
    end
    flush   = 1'b1;
    in_data = 16'sd100;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (prod_valid !== 1'b0 || sum_valid !== 1'b0 || prod[0] !== 32'sd27) begin
      errors++;
      $display("FAIL flush_edge: valid=%b sum_valid=%b prod0=%0d required 0 0 27",
               prod_valid, sum_valid, prod[0]);
    end
    bad = 0;
    for (int i = 0; i < TREE_STAGES + 4; i++) begin
      tick();
      if (prod_valid !== 1'b0 || sum_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_no_pulses: %0d cycles with a valid, required 0", bad);
    end
    in_valid = 1'b1;
    in_data  = 16'sd1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (prod_valid !== 1'b1 || sum_prod() != 64'sd3) begin
      errors++;
      $display("FAIL flush_cleared_line: valid=%b sum=%0d required 1 3", prod_valid, sum_prod());
    end
    readback(5, v);
    checks++;
    if (v !== 32'sd6) begin
      errors++;
      $display("FAIL flush_coef5: c_act5=%0d required 6", v);
    end
    readback(3, v);
    checks++;
    if (v !== 32'sd9) begin
      errors++;
      $display("FAIL flush_coef3: c_act3=%0d required 9", v);
    end
    $display("test_flush: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    do_flush();
    in_valid = 1'b1;
    in_data  = 16'sd5;
    tick();
    tick();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    checks++;
    if (swap_pending !== 1'b1 || prod[0] !== 32'sd15) begin
      errors++;
      $display("FAIL areset_pre: pending=%b prod0=%0d required 1 15", swap_pending, prod[0]);
    end
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (prod_valid !== 1'b0 || sum_valid !== 1'b0 || swap_pending !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL areset_flags: valid=%b sum_valid=%b pending=%b done=%b required 0 0 0 0",
               prod_valid, sum_valid, swap_pending, swap_done);
    end
    checks++;
    if (nonzero_prods() != 0) begin
      errors++;
      $display("FAIL areset_prod: %0d nonzero products, required 0", nonzero_prods());
    end
    in_valid = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (prod_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_edge1: valid=%b required 0", prod_valid);
    end
    tick();
    checks++;
    if (prod_valid !== 1'b1 || prod[0] !== '0 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL areset_edge2: valid=%b prod0=%0d pending=%b required 1 0 0",
               prod_valid, prod[0], swap_pending);
    end
    $display("test_async_reset: done, checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_latency();
    test_signed();
    test_swap_traffic();
    test_same_edge();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
